// File: rtl/lifo_stack_pkg.sv
// Shared constants, operation encoding and sizing helper for the LIFO stack.
package lifo_stack_pkg;

   localparam int DEF_ADRS_BITS = 2;
   localparam int DEF_WORD_BITS = 4;

   // Resolved action for one clock edge, decoded from the request and occupancy.
   typedef enum logic [2:0] {
      OP_IDLE,
      OP_PUSH,
      OP_POP,
      OP_REPLACE,
      OP_OVERFLOW,
      OP_UNDERFLOW
   } op_t;

   // One extra bit so the count can hold DEPTH itself.
   function automatic int count_width(input int adrs_bits);
      return adrs_bits + 1;
   endfunction

endpackage

// File: rtl/stack_reg_file.sv
// Stack storage: one synchronous write port, one asynchronous read port.
module stack_reg_file #(
   parameter int ADRS_BITS = 2,
   parameter int WORD_BITS = 4
) (
   input  logic                 clk,
   input  logic                 wr_en,
   input  logic [ADRS_BITS-1:0] wr_addr,
   input  logic [WORD_BITS-1:0] wr_data,
   input  logic [ADRS_BITS-1:0] rd_addr,
   output logic [WORD_BITS-1:0] rd_data
);

   localparam int DEPTH = 2**ADRS_BITS;

   logic [WORD_BITS-1:0] mem [DEPTH];

   // NOTE: storage carries no reset; validity is tracked by the count, so a reset
   // here would only add fan-out and block RAM inference.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lifo_stack_pro.sv
// Show-ahead LIFO stack with replace-top, almost-full threshold and sticky error flags.
module lifo_stack_pro
   import lifo_stack_pkg::*;
#(
   parameter int ADRS_BITS = DEF_ADRS_BITS,
   parameter int WORD_BITS = DEF_WORD_BITS,
   parameter int AF_LEVEL  = (2**ADRS_BITS) - 1
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 push,
   input  logic                                 pop,
   input  logic                                 clr_err,
   input  logic [WORD_BITS-1:0]                 push_data,
   output logic [WORD_BITS-1:0]                 pop_data,
   output logic                                 empty,
   output logic                                 full,
   output logic                                 almost_full,
   output logic [count_width(ADRS_BITS)-1:0]    count,
   output logic                                 overflow,
   output logic                                 underflow
);

   localparam int DEPTH = 2**ADRS_BITS;
   localparam int CW    = count_width(ADRS_BITS);

   op_t                  op;
   logic                 wr_en;
   logic [ADRS_BITS-1:0] top_addr;
   logic [ADRS_BITS-1:0] wr_addr;
   logic [WORD_BITS-1:0] rd_data;

   assign empty       = (count == '0);
   assign full        = (count == CW'(DEPTH));
   assign almost_full = (count >= CW'(AF_LEVEL));

   // NOTE: op gets a default before the case so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      op = OP_IDLE;
      casez ({push, pop, empty, full})
         4'b111?: op = OP_PUSH;       // push+pop on empty behaves as a plain push
         4'b110?: op = OP_REPLACE;
         4'b10?1: op = OP_OVERFLOW;
         4'b10?0: op = OP_PUSH;
         4'b011?: op = OP_UNDERFLOW;
         4'b010?: op = OP_POP;
         default: op = OP_IDLE;
      endcase
   end

   assign top_addr = ADRS_BITS'(count - CW'(1));
   assign wr_en    = rst && ((op == OP_PUSH) || (op == OP_REPLACE));
   assign wr_addr  = (op == OP_REPLACE) ? top_addr : ADRS_BITS'(count);

   stack_reg_file #(
      .ADRS_BITS (ADRS_BITS),
      .WORD_BITS (WORD_BITS)
   ) u_reg_file (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (push_data),
      .rd_addr (top_addr),
      .rd_data (rd_data)
   );

   assign pop_data = empty ? '0 : rd_data;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         case (op)
            OP_PUSH: count <= count + CW'(1);
            OP_POP:  count <= count - CW'(1);
            default: count <= count;
         endcase

         // A new error event outranks a simultaneous clear.
         if (op == OP_OVERFLOW) begin
            overflow <= 1'b1;
         end else if (clr_err) begin
            overflow <= 1'b0;
         end

         if (op == OP_UNDERFLOW) begin
            underflow <= 1'b1;
         end else if (clr_err) begin
            underflow <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_lifo_stack_pro.sv
// Self-checking bench for lifo_stack_pro: directed vector table, corner sequence, random vs queue model.
module tb_lifo_stack_pro;

   localparam int ADRS_BITS = 2;
   localparam int WORD_BITS = 4;
   localparam int AF_LEVEL  = 3;
   localparam int DEPTH     = 4;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic                 push = 1'b0;
   logic                 pop = 1'b0;
   logic                 clr_err = 1'b0;
   logic [WORD_BITS-1:0] push_data = '0;
   logic [WORD_BITS-1:0] pop_data;
   logic                 empty;
   logic                 full;
   logic                 almost_full;
   logic [ADRS_BITS:0]   count;
   logic                 overflow;
   logic                 underflow;

   int n_checks = 0;
   int n_fail   = 0;

   lifo_stack_pro #(
      .ADRS_BITS (ADRS_BITS),
      .WORD_BITS (WORD_BITS),
      .AF_LEVEL  (AF_LEVEL)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .push        (push),
      .pop         (pop),
      .clr_err     (clr_err),
      .push_data   (push_data),
      .pop_data    (pop_data),
      .empty       (empty),
      .full        (full),
      .almost_full (almost_full),
      .count       (count),
      .overflow    (overflow),
      .underflow   (underflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       push;
      logic       pop;
      logic       clr;
      logic [3:0] data;
      int         cnt;
      int         pd;
      logic       ovf;
      logic       udf;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Occupancy-derived flags are computed here from the expected count.
   task automatic check_all(input string tag, input int cnt, input int pd,
                            input logic ovf, input logic udf);
      check({tag, " count"},       int'(count),       cnt);
      check({tag, " pop_data"},    int'(pop_data),    pd);
      check({tag, " empty"},       int'(empty),       int'(cnt == 0));
      check({tag, " full"},        int'(full),        int'(cnt == DEPTH));
      check({tag, " almost_full"}, int'(almost_full), int'(cnt >= AF_LEVEL));
      check({tag, " overflow"},    int'(overflow),    int'(ovf));
      check({tag, " underflow"},   int'(underflow),   int'(udf));
   endtask

   task automatic step(input logic r, input logic pu, input logic po,
                       input logic ce, input logic [3:0] d);
      rst       = r;
      push      = pu;
      pop       = po;
      clr_err   = ce;
      push_data = d;
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic r, input logic pu, input logic po, input logic ce,
                               input logic [3:0] d, input int cnt, input int pd,
                               input logic ovf, input logic udf);
      vec_t v;
      v.rst = r; v.push = pu; v.pop = po; v.clr = ce; v.data = d;
      v.cnt = cnt; v.pd = pd; v.ovf = ovf; v.udf = udf;
      return v;
   endfunction

   // Behavioural model state for the random phase.
   int   model_q[$];
   logic m_ovf;
   logic m_udf;

   initial begin
      // Directed table: rst, push, pop, clr, data -> count, pop_data, ovf, udf
      vecs.push_back(mk(0, 0, 0, 0, 4'h0, 0, 0, 0, 0));   // reset
      vecs.push_back(mk(1, 1, 0, 0, 4'h1, 1, 1, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 4'h3, 2, 3, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 4'h5, 3, 5, 0, 0));   // almost_full
      vecs.push_back(mk(1, 1, 0, 0, 4'h7, 4, 7, 0, 0));   // full
      vecs.push_back(mk(1, 1, 0, 1, 4'h9, 4, 7, 1, 0));   // overflow beats clr_err
      vecs.push_back(mk(1, 0, 0, 0, 4'h0, 4, 7, 1, 0));   // sticky hold
      vecs.push_back(mk(1, 0, 0, 1, 4'h0, 4, 7, 0, 0));   // clear
      vecs.push_back(mk(1, 1, 1, 0, 4'hE, 4, 14, 0, 0));  // replace while full
      vecs.push_back(mk(1, 1, 1, 0, 4'h7, 4, 7, 0, 0));   // restore top
      vecs.push_back(mk(1, 0, 1, 0, 4'h0, 3, 5, 0, 0));
      vecs.push_back(mk(1, 0, 1, 0, 4'h0, 2, 3, 0, 0));
      vecs.push_back(mk(1, 0, 1, 0, 4'h0, 1, 1, 0, 0));
      vecs.push_back(mk(1, 0, 1, 0, 4'h0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 1, 0, 4'h0, 0, 0, 0, 1));   // underflow
      vecs.push_back(mk(1, 0, 0, 1, 4'h0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 4'h2, 1, 2, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 4'h4, 2, 4, 0, 0));
      vecs.push_back(mk(1, 1, 1, 0, 4'h6, 2, 6, 0, 0));   // replace-top
      vecs.push_back(mk(1, 0, 1, 0, 4'h0, 1, 2, 0, 0));
      vecs.push_back(mk(1, 0, 1, 0, 4'h0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 1, 0, 4'h8, 1, 8, 0, 0));   // push+pop on empty
      vecs.push_back(mk(1, 1, 0, 0, 4'hA, 2, 10, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 4'hB, 3, 11, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 4'hC, 0, 0, 0, 0));   // reset wins over push

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].rst, vecs[i].push, vecs[i].pop, vecs[i].clr, vecs[i].data);
         check_all($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].pd, vecs[i].ovf, vecs[i].udf);
      end

      // Corner: both sticky flags set, held across idle cycles, cleared by reset.
      step(1, 0, 1, 0, 4'h0);
      for (int i = 0; i < DEPTH; i++) step(1, 1, 0, 0, 4'(i + 3));
      step(1, 1, 0, 0, 4'hF);
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 4'h0);
      check_all("sticky_hold", 4, 6, 1, 1);
      step(0, 0, 1, 0, 4'h0);
      check_all("reset_flags", 0, 0, 0, 0);

      // Random phase against a queue model.
      model_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         logic r, pu, po, ce;
         logic [3:0] d;
         logic ovf_ev, udf_ev;
         r  = ($urandom_range(0, 99) >= 3);
         pu = ($urandom_range(0, 99) < 50);
         po = ($urandom_range(0, 99) < 45);
         ce = ($urandom_range(0, 99) < 10);
         d  = 4'($urandom);
         ovf_ev = 1'b0;
         udf_ev = 1'b0;
         if (!r) begin
            model_q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
         end else begin
            if (pu && po) begin
               if (model_q.size() == 0) model_q.push_back(int'(d));
               else model_q[model_q.size() - 1] = int'(d);
            end else if (pu) begin
               if (model_q.size() == DEPTH) ovf_ev = 1'b1;
               else model_q.push_back(int'(d));
            end else if (po) begin
               if (model_q.size() == 0) udf_ev = 1'b1;
               else void'(model_q.pop_back());
            end
            m_ovf = ovf_ev ? 1'b1 : (ce ? 1'b0 : m_ovf);
            m_udf = udf_ev ? 1'b1 : (ce ? 1'b0 : m_udf);
         end
         step(r, pu, po, ce, d);
         check_all($sformatf("rand%0d", cyc), model_q.size(),
                   (model_q.size() == 0) ? 0 : model_q[model_q.size() - 1], m_ovf, m_udf);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lifo_stack_pro.md
LIFO_STACK_PRO -- requirements
Module: lifo_stack_pro

Interface
REQ-001 Parameter ADRS_BITS, default 2, meaning address width; depth DEPTH = 2**ADRS_BITS entries.
REQ-002 Parameter WORD_BITS, default 4, meaning data word width.
REQ-003 Parameter AF_LEVEL, default DEPTH-1, meaning almost_full threshold in entries (1..DEPTH).
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 push  input  1  write request.
REQ-007 pop  input  1  read/remove request.
REQ-008 clr_err  input  1  clears sticky error flags.
REQ-009 push_data  input  WORD_BITS  word to push.
REQ-010 pop_data  output  WORD_BITS  current top-of-stack word (show-ahead).
REQ-011 empty  output  1  count == 0.
REQ-012 full  output  1  count == DEPTH.
REQ-013 almost_full  output  1  count >= AF_LEVEL.
REQ-014 count  output  ADRS_BITS+1  number of stored entries, 0..DEPTH.
REQ-015 overflow  output  1  sticky: push rejected while full.
REQ-016 underflow  output  1  sticky: pop rejected while empty.

Function
REQ-017 pop_data SHALL equal the most recently pushed, not yet popped entry combinationally from stored state, and 0 when empty.
REQ-018 Push only, not full: entry written at index count, count+1 on same edge; new word visible on pop_data next cycle.
REQ-019 Pop only, not empty: count-1; pop_data shows the entry below next cycle; storage not cleared.
REQ-020 Push and pop, not empty: top entry replaced by push_data, count unchanged (replace-top mode).
REQ-021 Push and pop, empty: treated as push only; underflow not set.
REQ-022 Push and pop, full: replace-top per REQ-020; overflow not set.
REQ-023 Push only while full: no write, count unchanged, overflow set next edge.
REQ-024 Pop only while empty: no change, underflow set next edge.
REQ-025 Sticky flags: hold until clr_err; clr_err and new error event in same cycle -> flag set (event wins).
REQ-026 empty, full, almost_full SHALL be decoded from the count register only, no separate flag state.
REQ-027 count arithmetic SHALL be ADRS_BITS+1 bits, never wrapping past 0 or DEPTH.

Reset
REQ-028 rst low at a clock edge: count=0, overflow=0, underflow=0; so empty=1, full=0, almost_full=0 (AF_LEVEL>=1), pop_data=0.
REQ-029 Storage array SHALL NOT be reset; reset mid-operation discards all entries and ignores push/pop in that cycle.

Structure
REQ-030 Package lifo_stack_pkg SHALL hold default parameter constants and a function computing count width from ADRS_BITS.
REQ-031 Storage SHALL be sub-module stack_reg_file (1 write port, 1 async read port, no reset); control, count and flags in lifo_stack_pro.
REQ-032 Control logic SHALL be a single next-state decode of {push, pop, empty, full}.

Verification (ADRS_BITS=2, WORD_BITS=4, AF_LEVEL=3)
REQ-033 Reset, then push 1,3,5,7 -> count 1..4, almost_full at count 3, full at 4, pop_data=7.
REQ-034 Full, push 9 -> count 4, pop_data 7, overflow=1; pulse clr_err -> overflow=0.
REQ-035 Pop x4 -> pop_data 5,3,1,0, empty=1; fifth pop -> underflow=1, count 0.
REQ-036 Push 2,4; push+pop with 6 -> count 2, pop_data 6; pop -> pop_data 2.
REQ-037 Empty, push+pop with 8 -> count 1, pop_data 8, underflow=0.
REQ-038 Count 3, rst low one cycle with push=1 -> count 0, empty=1, flags 0.
